// File: rtl/video_timing_ctl.sv
// Video timing sequencer: half-pixel phase, h/v counters, blanking, syncs and the
// vertical-blank interrupt request with a set/clear handshake.
module video_timing_ctl #(
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_TOTAL  = 384,
    parameter int unsigned V_ACTIVE = 224,
    parameter int unsigned V_FP     = 16,
    parameter int unsigned V_SYNC   = 8,
    parameter int unsigned V_TOTAL  = 264
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       irq_en,
    input  logic       irq_clr,
    output logic       h_half,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic       hblank,
    output logic       vblank,
    output logic       cmpblk2,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       vblank_start,
    output logic       irq
);

    // 10-bit bounds so a sync end of 512 does not wrap.
    localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
    localparam logic [9:0] HActive   = 10'(H_ACTIVE);
    localparam logic [9:0] VActive   = 10'(V_ACTIVE);
    localparam logic [9:0] HSyncBeg  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VSyncBeg  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd  = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic RstHblank  = (HLast >= HActive);
    localparam logic RstVblank  = (VLast >= VActive);
    localparam logic RstHsyncN  = !((HLast >= HSyncBeg) && (HLast < HSyncEnd));
    localparam logic RstVsyncN  = !((VLast >= VSyncBeg) && (VLast < VSyncEnd));

    typedef enum logic {StIdle, StPend} irq_state_e;

    irq_state_e irq_state;

    logic       half_d;
    logic [8:0] hcnt_d;
    logic [8:0] vcnt_d;
    logic       hblank_d;
    logic       vblank_d;
    logic       hsync_n_d;
    logic       vsync_n_d;
    logic       vblank_start_d;
    logic       irq_set;

    always_comb begin
        half_d = ~h_half;
        hcnt_d = hcnt;
        vcnt_d = vcnt;
        if (h_half) begin
            if ({1'b0, hcnt} == HLast) begin
                hcnt_d = '0;
                vcnt_d = ({1'b0, vcnt} == VLast) ? 9'd0 : vcnt + 9'd1;
            end else begin
                hcnt_d = hcnt + 9'd1;
            end
        end
    end

    // Decode from next-state counters so the registered flags line up with hcnt/vcnt.
    always_comb begin
        hblank_d       = ({1'b0, hcnt_d} >= HActive);
        vblank_d       = ({1'b0, vcnt_d} >= VActive);
        hsync_n_d      = !(({1'b0, hcnt_d} >= HSyncBeg) && ({1'b0, hcnt_d} < HSyncEnd));
        vsync_n_d      = !(({1'b0, vcnt_d} >= VSyncBeg) && ({1'b0, vcnt_d} < VSyncEnd));
        vblank_start_d = ({1'b0, vcnt_d} == VActive) && (hcnt_d == 9'd0) && !half_d;
    end

    assign irq_set = vblank_start & irq_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_half       <= 1'b1;
            hcnt         <= HLast[8:0];
            vcnt         <= VLast[8:0];
            hblank       <= RstHblank;
            vblank       <= RstVblank;
            cmpblk2      <= RstHblank | RstVblank;
            hsync_n      <= RstHsyncN;
            vsync_n      <= RstVsyncN;
            vblank_start <= 1'b0;
            irq_state    <= StIdle;
        end else begin
            h_half       <= half_d;
            hcnt         <= hcnt_d;
            vcnt         <= vcnt_d;
            hblank       <= hblank_d;
            vblank       <= vblank_d;
            cmpblk2      <= hblank_d | vblank_d;
            hsync_n      <= hsync_n_d;
            vsync_n      <= vsync_n_d;
            vblank_start <= vblank_start_d;
            unique case (irq_state)
                StIdle:  if (irq_set) irq_state <= StPend;
                // A simultaneous set keeps the request pending.
                StPend:  if (irq_clr && !irq_set) irq_state <= StIdle;
                default: irq_state <= StIdle;
            endcase
        end
    end

    assign irq = (irq_state == StPend);

endmodule

// File: tb/tb_video_timing_ctl.sv
// Bench for video_timing_ctl: default-geometry and reduced-geometry instances checked every
// cycle against a cycle-index model, plus hand-computed pins and randomized irq/reset stimulus.
module tb_video_timing_ctl;

    localparam int D_HA = 256, D_HF = 16, D_HS = 32, D_HT = 384;
    localparam int D_VA = 224, D_VF = 16, D_VS = 8,  D_VT = 264;
    localparam int S_HA = 16,  S_HF = 4,  S_HS = 6,  S_HT = 32;
    localparam int S_VA = 12,  S_VF = 2,  S_VS = 3,  S_VT = 20;

    typedef struct packed {
        logic       half;
        logic [8:0] h;
        logic [8:0] v;
        logic       hb;
        logic       vb;
        logic       cb;
        logic       hs;
        logic       vs;
        logic       vbs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq_en = 1'b1;
    logic irq_clr = 1'b0;

    logic       half0, hb0, vb0, cb0, hs0, vs0, vbs0, irq0;
    logic [8:0] h0, v0;
    logic       half1, hb1, vb1, cb1, hs1, vs1, vbs1, irq1;
    logic [8:0] h1, v1;
    exp_t       a0, a1;

    int n_tests = 0;
    int n_fail  = 0;

    bit chk_on = 1'b0;
    bit m_rst  = 1'b1;
    int m_k    = 0;
    bit m_irq0 = 1'b0;
    bit m_irq1 = 1'b0;

    always #5 clk = ~clk;

    video_timing_ctl u_def (
        .clk(clk), .rst_n(rst_n), .irq_en(irq_en), .irq_clr(irq_clr),
        .h_half(half0), .hcnt(h0), .vcnt(v0), .hblank(hb0), .vblank(vb0), .cmpblk2(cb0),
        .hsync_n(hs0), .vsync_n(vs0), .vblank_start(vbs0), .irq(irq0)
    );

    video_timing_ctl #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_TOTAL(S_HT),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_TOTAL(S_VT)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .irq_en(irq_en), .irq_clr(irq_clr),
        .h_half(half1), .hcnt(h1), .vcnt(v1), .hblank(hb1), .vblank(vb1), .cmpblk2(cb1),
        .hsync_n(hs1), .vsync_n(vs1), .vblank_start(vbs1), .irq(irq1)
    );

    assign a0 = {half0, h0, v0, hb0, vb0, cb0, hs0, vs0, vbs0};
    assign a1 = {half1, h1, v1, hb1, vb1, cb1, hs1, vs1, vbs1};

    // Expected outputs from the cycle index k since release (k counts clk cycles).
    function automatic exp_t model(int g, bit in_rst, int k);
        int ha, hf, hs, ht, va, vf, vs, vt, h, v, p;
        bit half;
        exp_t e;
        if (g == 0) begin
            ha = D_HA; hf = D_HF; hs = D_HS; ht = D_HT; va = D_VA; vf = D_VF; vs = D_VS; vt = D_VT;
        end else begin
            ha = S_HA; hf = S_HF; hs = S_HS; ht = S_HT; va = S_VA; vf = S_VF; vs = S_VS; vt = S_VT;
        end
        if (in_rst) begin
            half = 1'b1; h = ht - 1; v = vt - 1;
        end else begin
            p = k / 2; half = (k % 2) == 1; h = p % ht; v = (p / ht) % vt;
        end
        e.half = half;
        e.h    = 9'(h);
        e.v    = 9'(v);
        e.hb   = h >= ha;
        e.vb   = v >= va;
        e.cb   = (h >= ha) || (v >= va);
        e.hs   = !(h >= ha + hf && h < ha + hf + hs);
        e.vs   = !(v >= va + vf && v < va + vf + vs);
        e.vbs  = !in_rst && v == va && h == 0 && !half;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e0, e1;
        if (!rst_n) begin
            m_rst  <= 1'b1;
            m_k    <= 0;
            m_irq0 <= 1'b0;
            m_irq1 <= 1'b0;
        end else if (m_rst) begin
            m_rst <= 1'b0;
            m_k   <= 0;
        end else begin
            e0 = model(0, 1'b0, m_k);
            e1 = model(1, 1'b0, m_k);
            m_irq0 <= (e0.vbs && irq_en) ? 1'b1 : (irq_clr ? 1'b0 : m_irq0);
            m_irq1 <= (e1.vbs && irq_en) ? 1'b1 : (irq_clr ? 1'b0 : m_irq1);
            m_k    <= m_k + 1;
        end
    end

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d (k=%0d rst=%0d)", name, act, exp, m_k,
                         m_rst);
        end
    endtask

    task automatic cmp_all(string tag, exp_t a, exp_t e, logic ai, bit ei);
        chk({tag, ".h_half"}, a.half, e.half);
        chk({tag, ".hcnt"}, a.h, e.h);
        chk({tag, ".vcnt"}, a.v, e.v);
        chk({tag, ".hblank"}, a.hb, e.hb);
        chk({tag, ".vblank"}, a.vb, e.vb);
        chk({tag, ".cmpblk2"}, a.cb, e.cb);
        chk({tag, ".hsync_n"}, a.hs, e.hs);
        chk({tag, ".vsync_n"}, a.vs, e.vs);
        chk({tag, ".vblank_start"}, a.vbs, e.vbs);
        chk({tag, ".irq"}, ai, ei);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp_all("def", a0, model(0, m_rst, m_k), irq0, m_irq0);
            cmp_all("small", a1, model(1, m_rst, m_k), irq1, m_irq1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_k(int t);
        int n = 0;
        while (m_rst || m_k != t) begin
            step();
            n++;
            if (n > 60000) begin
                n_tests++;
                n_fail++;
                $display("FAIL wait_k: got k=%0d expected k=%0d within budget", m_k, t);
                return;
            end
        end
    endtask

    initial begin
        int c_hb, c_hs, c_vbs, c_vb, c_vs;
        rst_n = 1'b0; irq_en = 1'b1; irq_clr = 1'b0;
        step();
        chk_on = 1'b1;
        repeat (4) step();
        chk("rst.def_hcnt", h0, 383);
        chk("rst.def_vcnt", v0, 263);
        chk("rst.def_h_half", half0, 1);
        chk("rst.def_cmpblk2", cb0, 1);
        chk("rst.def_irq", irq0, 0);
        chk("rst.small_hcnt", h1, 31);

        rst_n = 1'b1;
        step();
        chk("rel.def_h_half", half0, 0);
        chk("rel.def_hcnt", h0, 0);
        chk("rel.def_vcnt", v0, 0);
        chk("rel.def_cmpblk2", cb0, 0);

        c_hb = 0; c_hs = 0; c_vbs = 0; c_vb = 0; c_vs = 0;
        for (int i = 0; i < 1280; i++) begin
            if (i < 768) begin
                c_hb += int'(hb0);
                c_hs += int'(!hs0);
            end
            c_vbs += int'(vbs1);
            c_vb  += int'(vb1);
            c_vs  += int'(!vs1);
            if (i == 768) begin
                chk("line.def_hcnt", h0, 0);
                chk("line.def_vcnt", v0, 1);
                chk("frame.small_vbs", vbs1, 1);
                chk("frame.small_irq_before", irq1, 0);
            end
            if (i == 769) chk("frame.small_irq_rise", irq1, 1);
            irq_clr = (i == 800);
            if (i == 801) chk("irq.clr_fall", irq1, 0);
            step();
        end
        chk("line.hblank_clks", c_hb, 256);
        chk("line.hsync_clks", c_hs, 64);
        chk("frame.vbs_pulses", c_vbs, 1);
        chk("frame.vblank_clks", c_vb, 512);
        chk("frame.vsync_clks", c_vs, 192);
        chk("frame.wrap_hcnt", h1, 0);
        chk("frame.wrap_vcnt", v1, 0);

        wait_k(2048); irq_clr = 1'b1;
        wait_k(2049); irq_clr = 1'b0;
        chk("irq.set_wins", irq1, 1);
        wait_k(2100); irq_clr = 1'b1;
        step(); irq_clr = 1'b0;
        wait_k(2560); irq_en = 1'b0;
        wait_k(3329); chk("irq.en0_blocks", irq1, 0);
        wait_k(3500); irq_en = 1'b1;
        wait_k(4609); chk("irq.en1_sets", irq1, 1);
        wait_k(4700); irq_en = 1'b0;
        wait_k(5889); chk("irq.en0_keeps", irq1, 1);
        wait_k(5900); irq_clr = 1'b1;
        step(); irq_clr = 1'b0;
        chk("irq.clr_after_hold", irq1, 0);
        wait_k(6000); irq_en = 1'b1;

        wait_k(8000);
        chk("midrst.vcnt", v1, 5);
        chk("midrst.irq_pending", irq1, 1);
        rst_n = 1'b0;
        step();
        chk("midrst.irq", irq1, 0);
        chk("midrst.hcnt", h1, 31);
        chk("midrst.vcnt_rst", v1, 19);
        chk("midrst.def_hcnt", h0, 383);
        rst_n = 1'b1;
        step();
        chk("midrst.rel_hcnt", h1, 0);
        chk("midrst.rel_vcnt", v1, 0);
        chk("midrst.rel_half", half1, 0);

        for (int i = 0; i < 8000; i++) begin
            irq_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) irq_en = ~irq_en;
            rst_n = ($urandom_range(0, 1499) != 0);
            step();
        end
        rst_n = 1'b1; irq_clr = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_ctl.md
# video_timing_ctl

Video timing sequencer for the pixel pipeline. Generates the half-pixel phase, horizontal/vertical pixel counters, blanking, composite blank and syncs that drive the palette stage and the tile/sprite fetchers. Also owns the CPU vertical-blank interrupt request with a set/clear handshake. `clk` runs at twice the pixel rate, so every pixel occupies two `clk` cycles.

## Interface
Parameters:
- H_ACTIVE, 256: visible pixels per line
- H_FP, 16: pixels from end of active to hsync start
- H_SYNC, 32: hsync width in pixels
- H_TOTAL, 384: pixels per line
- V_ACTIVE, 224: visible lines per frame
- V_FP, 16: lines from end of active to vsync start
- V_SYNC, 8: vsync width in lines
- V_TOTAL, 264: lines per frame

Ports:
- clk  in  1  clock, 2x pixel rate
- rst_n  in  1  reset, synchronous, active-low
- irq_en  in  1  enables latching of vblank interrupt
- irq_clr  in  1  one-cycle pulse clearing irq
- h_half  out  1  pixel phase: 0 = first half, 1 = second half
- hcnt  out  9  horizontal pixel index
- vcnt  out  9  line index
- hblank  out  1  hcnt >= H_ACTIVE
- vblank  out  1  vcnt >= V_ACTIVE
- cmpblk2  out  1  hblank | vblank
- hsync_n  out  1  active-low hsync
- vsync_n  out  1  active-low vsync
- vblank_start  out  1  one-clk pulse at first cycle of vblank
- irq  out  1  vblank interrupt request, level

## Operation
- Parameter legality: H_ACTIVE+H_FP+H_SYNC <= H_TOTAL <= 512, V_ACTIVE+V_FP+V_SYNC <= V_TOTAL <= 512. Violations are out of scope.
- `h_half` toggles every `clk`.
- On a clk edge with h_half=1, hcnt advances. If hcnt = H_TOTAL-1, it wraps to 0 and the vertical step occurs.
- Vertical step: vcnt increments. If vcnt = V_TOTAL-1, it wraps to 0.
- Counters use 9-bit unsigned arithmetic and never exceed TOTAL-1.
- All decoded outputs are registered and consistent with the hcnt/vcnt/h_half values presented in the same cycle. The implementation decodes from next-state values; there is no extra pipeline lag.
- hsync_n = 0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
- vsync_n = 0 iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC. It changes only at line wrap.
- vblank_start = 1 for exactly one clk: the cycle where vcnt=V_ACTIVE, hcnt=0, h_half=0.
- irq state machine:
  - States IDLE (irq=0) and PEND (irq=1).
  - IDLE→PEND when vblank_start & irq_en.
  - PEND→IDLE on irq_clr.
  - If set and clear arrive in the same cycle, set wins and the state stays or goes PEND.
  - irq_en=0 blocks new sets only; it does not clear a pending irq.

## Timing
- Reset values (held while rst_n=0 at every edge):
  - h_half=1, hcnt=H_TOTAL-1, vcnt=V_TOTAL-1
  - hblank=1, vblank=1, cmpblk2=1
  - hsync_n=1, vsync_n=1 with default parameters; in general, decoded from the reset counters
  - vblank_start=0, irq=0 (IDLE)
- First edge after rst_n goes high: h_half=0, hcnt=0, vcnt=0, cmpblk2=0. Active video starts immediately.
- Line = 2*H_TOTAL clk (768 default). Frame = 2*H_TOTAL*V_TOTAL clk (202752 default).
- Palette stage contract: cmpblk2 is stable across both halves of a pixel. It changes only on the edge into h_half=0.
- irq rises on the edge after the vblank_start cycle and falls on the edge after the irq_clr cycle.
- Reset mid-frame: all state returns to reset values on the next edge, and a pending irq is dropped. No partial line is emitted after release; the sequence restarts at (0,0).

## Test plan
- Reset/release: hold rst_n=0 for 5 clk → h_half=1, hcnt=383, vcnt=263, cmpblk2=1, irq=0. Release → next cycle h_half=0, hcnt=0, vcnt=0, cmpblk2=0.
- Line wrap: run 768 clk from release → hcnt returns to 0, vcnt=1. hblank=1 for exactly hcnt 256..383 (256 clk). hsync_n=0 for hcnt 272..303 (64 clk).
- Frame: run 202752 clk → vcnt=0 and hcnt=0 again. vblank asserted for lines 224..263. vsync_n=0 for lines 240..247. Exactly one vblank_start pulse, at clk 224*768=172032 after release.
- Interrupt handshake, irq_en=1:
  - irq rises at clk 172033.
  - irq_clr pulse at 172100 → irq=0 from 172101.
  - irq_clr asserted on the vblank_start cycle of the next frame → irq=1 (set wins).
- irq_en=0 over a full frame → irq stays 0. Then set pending with irq_en=1, drop irq_en → irq stays 1 until irq_clr.
- Reset mid-frame at vcnt=100 with irq pending → one edge later all outputs equal reset values, irq=0. The post-release sequence is identical to the first scenario.
